config_loader: RTL and testbench

CONFIG_LOADER -- requirements
Module: config_loader

---
 rtl/config_loader.sv | 182 ++++++++++++++++++
 tb/tb_config_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// Serial configuration-chain loader: streams words from a valid/ready source
// into a bit-serial chain MSB first. Optional checksum stage: CONFIG_LOADER_CHECKSUM_EN.
module config_loader #(
  parameter int CHAIN_LENGTH = 24,
  parameter int WORD_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_enable,
  output logic                  cfg_data,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            state_dbg
);

  // Handshake: word_in is taken on a rising edge where word_valid & word_ready
  // are both 1. word_ready depends only on the state (FETCH or CHECK), never on
  // word_valid; a word held with word_valid=1 stays offered until taken.

  localparam int CW  = $clog2(CHAIN_LENGTH + 1);
  localparam int WBW = $clog2(WORD_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SHIFT = 3'd2,
`ifdef CONFIG_LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [WORD_WIDTH-1:0]   buf_q, buf_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [WBW-1:0]          wb_q, wb_d;
  logic                    ready_q, ready_d;
  logic                    en_q, en_d;
  logic                    data_q, data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    hs;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_WIDTH-1:0]   chk_q, chk_d;
  logic                    err_q, err_d;
`endif

  assign hs = word_valid & ready_q;

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    wb_d    = wb_q;
    ready_d = ready_q;
    en_d    = 1'b0;
    data_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          ready_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          cnt_d   = '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          chk_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      S_FETCH: begin
        if (hs) begin
          state_d = S_SHIFT;
          buf_d   = word_in;
          wb_d    = '0;
          ready_d = 1'b0;
          en_d    = 1'b1;
          data_d  = word_in[WORD_WIDTH-1];
`ifdef CONFIG_LOADER_CHECKSUM_EN
          chk_d   = chk_q ^ word_in;
`endif
        end
      end
      S_SHIFT: begin
        buf_d = buf_q << 1;
        cnt_d = cnt_q + CW'(1);
        wb_d  = wb_q + WBW'(1);
        // Chain-full wins over word-end: leftover bits of a partial word are dropped.
        if (cnt_q == CW'(CHAIN_LENGTH - 1)) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
          state_d = S_CHECK;
          ready_d = 1'b1;
`else
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
`endif
        end else if (wb_q == WBW'(WORD_WIDTH - 1)) begin
          state_d = S_FETCH;
          ready_d = 1'b1;
        end else begin
          en_d   = 1'b1;
          data_d = buf_d[WORD_WIDTH-1];
        end
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (hs) begin
          err_d   = (word_in != chk_q);
          state_d = S_DONE;
          ready_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      wb_q    <= '0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      chk_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      wb_q    <= wb_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CONFIG_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
      err_q   <= err_d;
`endif
    end
  end

  assign word_ready = ready_q;
  assign cfg_enable = en_q;
  assign cfg_data   = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;
`ifdef CONFIG_LOADER_CHECKSUM_EN
  assign error      = err_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (24-bit and 20-bit chains), a chain
// model capturing cfg_data, and a reference built from the bitstream rules.
module tb_config_loader;

  localparam int W  = 8;
  localparam int L0 = 24;
  localparam int L1 = 20;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  logic         start_s[2];
  logic         word_valid_s[2];
  logic [W-1:0] word_in_s[2];
  logic         word_ready_s[2];
  logic         cfg_enable_s[2];
  logic         cfg_data_s[2];
  logic         busy_s[2];
  logic         done_s[2];
  logic         error_s[2];
  logic [2:0]   state_s[2];

  config_loader #(.CHAIN_LENGTH(L0), .WORD_WIDTH(W)) u_dut24 (
    .clock(clock), .nreset(nreset), .start(start_s[0]), .word_in(word_in_s[0]),
    .word_valid(word_valid_s[0]), .word_ready(word_ready_s[0]),
    .cfg_enable(cfg_enable_s[0]), .cfg_data(cfg_data_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .error(error_s[0]), .state_dbg(state_s[0])
  );

  config_loader #(.CHAIN_LENGTH(L1), .WORD_WIDTH(W)) u_dut20 (
    .clock(clock), .nreset(nreset), .start(start_s[1]), .word_in(word_in_s[1]),
    .word_valid(word_valid_s[1]), .word_ready(word_ready_s[1]),
    .cfg_enable(cfg_enable_s[1]), .cfg_data(cfg_data_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .error(error_s[1]), .state_dbg(state_s[1])
  );

  // Downstream chain: shifts in cfg_data on every enabled cycle.
  logic [63:0] chain[2]  = '{64'd0, 64'd0};
  int          en_cnt[2] = '{0, 0};
  int          viol[2]   = '{0, 0};

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (cfg_enable_s[d]) begin
        chain[d]  <= {chain[d][62:0], cfg_data_s[d]};
        en_cnt[d] <= en_cnt[d] + 1;
      end
      if (cfg_data_s[d] && !cfg_enable_s[d]) viol[d] <= viol[d] + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];
  logic [W-1:0] wq[$];
  int          gq[$];
  bit          injected;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Reference: first L bits of the word stream, MSB of each word first.
  function automatic logic [63:0] model_chain(input int L);
    logic [63:0] v = 64'd0;
    int n = 0;
    foreach (wq[i]) begin
      for (int b = W - 1; b >= 0; b--) begin
        if (n < L) begin
          v = (v << 1) | 64'(wq[i][b]);
          n++;
        end
      end
    end
    return v;
  endfunction

  function automatic logic [W-1:0] model_xor();
    logic [W-1:0] x = '0;
    foreach (wq[i]) x ^= wq[i];
    return x;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic offer_word(input int d, input logic [W-1:0] w, input int gap, input bit inj);
    int to;
    for (int g = 0; g < gap; g++) begin
      word_valid_s[d] = 1'b0;
      word_in_s[d]    = W'($urandom);
      start_s[d]      = inj && !injected && cfg_enable_s[d];
      if (start_s[d]) injected = 1'b1;
      @(negedge clock);
    end
    word_valid_s[d] = 1'b1;
    word_in_s[d]    = w;
    to = 0;
    while (!word_ready_s[d] && to < 300) begin
      start_s[d] = inj && !injected && cfg_enable_s[d];
      if (start_s[d]) injected = 1'b1;
      @(negedge clock);
      to++;
    end
    start_s[d] = 1'b0;
    check("ready_timeout", 64'(to < 300), 64'd1);
    @(negedge clock);
    word_valid_s[d] = 1'b0;
    word_in_s[d]    = W'($urandom);
  endtask

  task automatic run_load(input int d, input bit inj, input bit bad_chk);
    int L;
    int base_en;
    int base_viol;
    int to;
    logic [63:0] mask;
    logic [W-1:0] cw;
    logic exp_err;
    L    = (d == 0) ? L0 : L1;
    mask = (64'd1 << L) - 64'd1;
    cw   = model_xor() ^ W'(bad_chk);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    exp_err = bad_chk;
`else
    exp_err = 1'b0;
`endif
    exp_q.push_back(model_chain(L));
    injected  = 1'b0;
    base_en   = en_cnt[d];
    base_viol = viol[d];
    @(negedge clock);
    start_s[d] = 1'b1;
    @(negedge clock);
    start_s[d] = 1'b0;
    check("busy_after_start", 64'(busy_s[d]), 64'd1);
    check("done_cleared", 64'(done_s[d]), 64'd0);
    foreach (wq[i]) offer_word(d, wq[i], gq[i], inj);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    offer_word(d, cw, 0, 1'b0);
`endif
    to = 0;
    while (!done_s[d] && to < 300) begin
      @(negedge clock);
      to++;
    end
    check("done_timeout", 64'(to < 300), 64'd1);
    @(negedge clock);
    check("chain", chain[d] & mask, exp_q.pop_front());
    check("enable_cycles", 64'(en_cnt[d] - base_en), 64'(L));
    check("done", 64'(done_s[d]), 64'd1);
    check("busy", 64'(busy_s[d]), 64'd0);
    check("ready_idle", 64'(word_ready_s[d]), 64'd0);
    check("enable_idle", 64'(cfg_enable_s[d]), 64'd0);
    check("error", 64'(error_s[d]), 64'(exp_err));
    check("data_without_enable", 64'(viol[d] - base_viol), 64'd0);
  endtask

  task automatic set_words(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                           input int g1);
    wq.delete();
    gq.delete();
    wq.push_back(a); wq.push_back(b); wq.push_back(c);
    gq.push_back(0); gq.push_back(g1); gq.push_back(0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_ready"}, 64'(word_ready_s[d]), 64'd0);
      check({tag, "_enable"}, 64'(cfg_enable_s[d]), 64'd0);
      check({tag, "_data"}, 64'(cfg_data_s[d]), 64'd0);
      check({tag, "_busy"}, 64'(busy_s[d]), 64'd0);
      check({tag, "_done"}, 64'(done_s[d]), 64'd0);
      check({tag, "_error"}, 64'(error_s[d]), 64'd0);
      check({tag, "_state"}, 64'(state_s[d]), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int to;
    int base_en;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      word_valid_s[d] = 1'b0;
      word_in_s[d] = '0;
    end
    #2;
    check_all_zero("reset");
    repeat (3) @(negedge clock);
    nreset = 1'b1;

    // Back-to-back words, good checksum 0x96 where built.
    set_words(8'hA5, 8'h3C, 8'h0F, 0);
    run_load(0, 1'b0, 1'b0);
    check("chain_a53c0f", chain[0] & 64'hFF_FFFF, 64'hA53C0F);
    // Same stream with checksum 0x97.
    run_load(0, 1'b0, 1'b1);
    // 20-bit chain drops the low nibble of 0xF0.
    set_words(8'hA5, 8'h3C, 8'hF0, 0);
    run_load(1, 1'b0, 1'b0);
    check("chain_a53cf", chain[1] & 64'hF_FFFF, 64'hA53CF);
    // Five-cycle valid gap before the second word.
    set_words(8'hA5, 8'h3C, 8'h0F, 5);
    run_load(0, 1'b0, 1'b0);
    // start pulsed while shifting is ignored.
    set_words(8'hA5, 8'h3C, 8'h0F, 0);
    run_load(0, 1'b1, 1'b0);

    // Reset partway through a load, then reload.
    base_en = en_cnt[0];
    @(negedge clock);
    start_s[0] = 1'b1;
    @(negedge clock);
    start_s[0] = 1'b0;
    offer_word(0, 8'hA5, 0, 1'b0);
    word_valid_s[0] = 1'b1;
    word_in_s[0] = 8'h3C;
    to = 0;
    while ((en_cnt[0] - base_en) < 10 && to < 100) begin
      @(negedge clock);
      to++;
    end
    check("partial_timeout", 64'(to < 100), 64'd1);
    #2 nreset = 1'b0;
    #1 check_all_zero("midload_reset");
    word_valid_s[0] = 1'b0;
    @(negedge clock);
    nreset = 1'b1;
    set_words(8'hA5, 8'h3C, 8'h0F, 0);
    run_load(0, 1'b0, 1'b0);

    // Randomized loads on both chain lengths.
    for (int it = 0; it < 10; it++) begin
      wq.delete();
      gq.delete();
      for (int k = 0; k < 3; k++) begin
        wq.push_back(W'($urandom));
        gq.push_back($urandom_range(0, 4));
      end
      run_load(it % 2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
